// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcode encoding, instruction field
// positions and the control FSM state type.
package alu_seq_pkg;

    localparam int INSTR_W  = 16;
    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;

    // Must track the external ALU's opcode decode exactly.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int LDI_BIT   = 15;
    localparam int LDI_RD_HI = 12;
    localparam int LDI_RD_LO = 11;
    localparam int IMM_HI    = 7;
    localparam int IMM_LO    = 0;
    localparam int OP_HI     = 14;
    localparam int OP_LO     = 12;
    localparam int RD_HI     = 11;
    localparam int RD_LO     = 10;
    localparam int RS_HI     = 9;
    localparam int RS_LO     = 8;
    localparam int RT_HI     = 7;
    localparam int RT_LO     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction stream, ALU drive/sample and result stream of the ALU sequencer.
interface alu_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [2:0]         alu_opcode;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_result;
    logic               res_valid;
    logic               res_ready;
    logic [DATA_W-1:0]  res_data;
    logic [REG_AW-1:0]  res_rd;

    modport master (
        input  instr_valid, instr, alu_result, res_ready,
        output instr_ready, alu_opcode, alu_a, alu_b, res_valid, res_data, res_rd
    );

    modport slave (
        output instr_valid, instr, alu_result, res_ready,
        input  instr_ready, alu_opcode, alu_a, alu_b, res_valid, res_data, res_rd
    );
endinterface

// File: rtl/seq_regfile.sv
// 4-entry register file: two combinational read ports, one synchronous write
// port, synchronous clear.
module seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/alu_sequencer.sv
// Accepts LDI / ALU instructions, drives an external combinational ALU for one
// cycle, writes the result back and reports it on a valid/ready stream.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.master   bus,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    state_e            state_q, state_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [REG_AW-1:0] res_rd_q, res_rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rs_data;
    logic [DATA_W-1:0] rf_rt_data;

    logic              is_ldi;
    logic [REG_AW-1:0] ldi_rd;
    logic [DATA_W-1:0] imm;
    logic [2:0]        op;
    logic [REG_AW-1:0] alu_rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;

    assign is_ldi = bus.instr[LDI_BIT];
    assign ldi_rd = bus.instr[LDI_RD_HI:LDI_RD_LO];
    assign imm    = bus.instr[IMM_HI:IMM_LO];
    assign op     = bus.instr[OP_HI:OP_LO];
    assign alu_rd = bus.instr[RD_HI:RD_LO];
    assign rs     = bus.instr[RS_HI:RS_LO];
    assign rt     = bus.instr[RT_HI:RT_LO];

    seq_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs),
        .rdata_a (rf_rs_data),
        .raddr_b (rt),
        .rdata_b (rf_rt_data)
    );

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        cnt_d      = cnt_q;
        rf_we      = 1'b0;
        rf_waddr   = rd_q;
        rf_wdata   = bus.alu_result;

        unique case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    if (is_ldi) begin
                        rf_we      = 1'b1;
                        rf_waddr   = ldi_rd;
                        rf_wdata   = imm;
                        res_data_d = imm;
                        res_rd_d   = ldi_rd;
                        state_d    = RESP;
                    end else begin
                        // Operands are captured now; the ALU sees stable registered inputs in EXEC.
                        opcode_d = op;
                        a_d      = rf_rs_data;
                        b_d      = rf_rt_data;
                        rd_d     = alu_rd;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                rf_we      = 1'b1;
                rf_waddr   = rd_q;
                rf_wdata   = bus.alu_result;
                res_data_d = bus.alu_result;
                res_rd_d   = rd_q;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == RESP);
    assign bus.alu_opcode  = opcode_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign busy            = (state_q != IDLE);
    assign op_count        = cnt_q;
endmodule
